// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, constants and IF/ID record for the fetch stage
package fetch_pkg;

    localparam int XLEN   = 64;
    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0]   PC_STEP  = 64'd4;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] instruction;
        logic              valid;
    } if_id_t;

    // A bubble carries no pc so downstream debug never sees a stale address.
    function automatic if_id_t if_id_bubble(input logic [INST_W-1:0] nop);
        if_id_t b;
        b.pc          = '0;
        b.instruction = nop;
        b.valid       = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// rtl/instruction_fetch_stage_if_id_register.sv - IF/ID holding register with hold and bubble controls
module if_id_register
    import fetch_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP_INST = fetch_pkg::NOP_INST
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   hold,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    // bubble wins over hold: a flush during a stall must still kill the slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= if_id_bubble(NOP_INST);
        end else if (bubble) begin
            q <= if_id_bubble(NOP_INST);
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - PC owner and IF/ID capture; optional FETCH_PERF_CNT_EN counters
module instruction_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0]   RESET_PC = 64'h0,
    parameter logic [XLEN-1:0]   PC_STEP  = fetch_pkg::PC_STEP,
    parameter logic [INST_W-1:0] NOP_INST = fetch_pkg::NOP_INST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_target,
    input  logic [INST_W-1:0] Instruction,
    output logic [XLEN-1:0]   Inst_Address,
    output logic [XLEN-1:0]   if_id_pc,
    output logic [INST_W-1:0] if_id_instruction,
    output logic              if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_count
`endif
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            ifid_hold;
    logic            ifid_bubble;
    logic            fetch_fire;
    if_id_t          ifid_d;
    if_id_t          ifid_q;

    assign Inst_Address = pc;

    always_comb begin
        pc_next     = pc;
        ifid_hold   = 1'b0;
        ifid_bubble = 1'b0;
        fetch_fire  = 1'b0;
        if (branch_taken) begin
            // targets are word aligned; low bits from EX are discarded
            pc_next     = branch_target & ~64'd3;
            ifid_bubble = 1'b1;
        end else if (flush) begin
            ifid_bubble = 1'b1;
            if (!stall) begin
                pc_next = pc + PC_STEP;
            end
        end else if (stall) begin
            ifid_hold = 1'b1;
        end else begin
            pc_next    = pc + PC_STEP;
            fetch_fire = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    always_comb begin
        ifid_d.pc          = pc;
        ifid_d.instruction = Instruction;
        ifid_d.valid       = 1'b1;
    end

    if_id_register #(
        .NOP_INST(NOP_INST)
    ) u_if_id_register (
        .clk    (clk),
        .reset  (reset),
        .hold   (ifid_hold),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign if_id_pc          = ifid_q.pc;
    assign if_id_instruction = ifid_q.instruction;
    assign if_id_valid       = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
    // a redirect during stall is not a stalled cycle: the pc moved
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (fetch_fire) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (stall && !branch_taken) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`else
    logic unused_fire;
    assign unused_fire = fetch_fire;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - directed table-driven bench for instruction_fetch_stage
module tb_instruction_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [31:0] Instruction;
    logic [63:0] Inst_Address;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int n_tests;
    int n_fail;

    logic [31:0] mem [4];

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0  = 32'h0285_3483;
    localparam logic [31:0] W1  = 32'h009A_84B3;
    localparam logic [31:0] W2  = 32'h0014_8493;
    localparam logic [31:0] W3  = 32'h0295_3423;

    assign Instruction = mem[Inst_Address[3:2]];

    instruction_fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .flush             (flush),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .Instruction       (Instruction),
        .Inst_Address      (Inst_Address),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction),
        .if_id_valid       (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count       (fetch_count),
        .stall_count       (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        br;
        logic [63:0] target;
        logic [63:0] exp_pc;
        logic [63:0] exp_ifid_pc;
        logic [31:0] exp_inst;
        logic        exp_valid;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] pc, input logic [63:0] ipc,
                             input logic [31:0] inst, input logic v);
        check({tag, ".pc"}, Inst_Address, pc);
        check({tag, ".if_id_pc"}, if_id_pc, ipc);
        check({tag, ".inst"}, {32'd0, if_id_instruction}, {32'd0, inst});
        check({tag, ".valid"}, {63'd0, if_id_valid}, {63'd0, v});
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic f, input logic b, input logic [63:0] t);
        stall         = s;
        flush         = f;
        branch_taken  = b;
        branch_target = t;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mem[0] = W0;
        mem[1] = W1;
        mem[2] = W2;
        mem[3] = W3;

        //            stall flush br  target                 pc                     ifid_pc                inst valid
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 64'h0,                64'h4,                 64'h0,                 W0,  1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 64'h0,                64'h8,                 64'h4,                 W1,  1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 64'h0,                64'h8,                 64'h4,                 W1,  1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 64'h0,                64'h8,                 64'h4,                 W1,  1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 64'h0,                64'h8,                 64'h4,                 W1,  1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 64'h0,                64'hC,                 64'h8,                 W2,  1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 64'h0,                64'h10,                64'hC,                 W3,  1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 64'hE,                64'hC,                 64'h0,                 NOP, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 64'h0,                64'h10,                64'hC,                 W3,  1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 64'h4,                64'h4,                 64'h0,                 NOP, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 64'h0,                64'h8,                 64'h0,                 NOP, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 64'h0,                64'h8,                 64'h0,                 NOP, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 64'h0,                64'hC,                 64'h8,                 W2,  1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0,            NOP, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 64'h0,                64'h0,                 64'hFFFF_FFFF_FFFF_FFFC, W3, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 64'h0,                64'h4,                 64'h0,                 W0,  1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 64'h0,                64'hC,                 64'h4,                 W1,  1'b1};
        vecs[16].br     = 1'b1;
        vecs[16].target = 64'hC;
        vecs[16].exp_ifid_pc = 64'h0;
        vecs[16].exp_inst    = NOP;
        vecs[16].exp_valid   = 1'b0;

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        #1 reset = 1'b0;
        #1;
        check_all("reset", 64'h0, 64'h0, NOP, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        check("reset.fetch_count", {32'd0, fetch_count}, 64'd0);
        check("reset.stall_count", {32'd0, stall_count}, 64'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].target);
            edge_step();
            check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_ifid_pc,
                      vecs[i].exp_inst, vecs[i].exp_valid);
            @(negedge clk);
        end

        // pc is 0xC here; advance once so IF/ID is valid, then reset between edges
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        edge_step();
        check_all("pre_async", 64'h10, 64'hC, W3, 1'b1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_all("async_reset", 64'h0, 64'h0, NOP, 1'b0);

        // release during a stall: the first edge must hold pc at RESET_PC
        @(negedge clk);
        stall = 1'b1;
        reset = 1'b1;
        edge_step();
        check_all("release_stall", 64'h0, 64'h0, NOP, 1'b0);
        @(negedge clk);
        stall = 1'b0;
        edge_step();
        check_all("after_release", 64'h4, 64'h0, W0, 1'b1);

        // fresh reset, 10 fetches then 3 stalls
        @(negedge clk);
        reset = 1'b0;
        #1 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            edge_step();
        end
        @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_step();
        end
        check_all("perf_run", 64'h28, 64'h24, W1, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count", {32'd0, fetch_count}, 64'd10);
        check("stall_count", {32'd0, stall_count}, 64'd3);
`endif
        @(negedge clk);
        stall = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
